// File: rtl/sha256_pkg.sv
// SHA-256 shared definitions: word type, round constants, IV and the
// combinational helpers used by the compression datapath.
package sha256_pkg;

  typedef logic [31:0] word_t;

  // a occupies the top word so the packed struct matches h_in/h_out packing
  typedef struct packed {
    word_t a;
    word_t b;
    word_t c;
    word_t d;
    word_t e;
    word_t f;
    word_t g;
    word_t h;
  } state_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROUND = 2'd1,
    ST_FINAL = 2'd2
  } fsm_t;

  localparam word_t K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam state_t IV = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  function automatic word_t rotr(input word_t x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic word_t s0(input word_t x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic word_t s1(input word_t x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  function automatic word_t S0(input word_t x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic word_t S1(input word_t x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic word_t ch(input word_t e, input word_t f, input word_t g);
    return (e & f) ^ (~e & g);
  endfunction

  function automatic word_t maj(input word_t a, input word_t b, input word_t c);
    return (a & b) ^ (a & c) ^ (b & c);
  endfunction

  // One compression round: returns the new a..h
  function automatic state_t round(input state_t s, input word_t w, input word_t k);
    word_t  t1;
    word_t  t2;
    state_t r;
    t1  = s.h + S1(s.e) + ch(s.e, s.f, s.g) + k + w;
    t2  = S0(s.a) + maj(s.a, s.b, s.c);
    r.a = t1 + t2;
    r.b = s.a;
    r.c = s.b;
    r.d = s.c;
    r.e = s.d + t1;
    r.f = s.e;
    r.g = s.f;
    r.h = s.g;
    return r;
  endfunction

  // Word-wise modulo-2^32 sum used for the final chaining update
  function automatic state_t add_state(input state_t x, input state_t y);
    state_t r;
    r.a = x.a + y.a;
    r.b = x.b + y.b;
    r.c = x.c + y.c;
    r.d = x.d + y.d;
    r.e = x.e + y.e;
    r.f = x.f + y.f;
    r.g = x.g + y.g;
    r.h = x.h + y.h;
    return r;
  endfunction

endpackage

// File: rtl/sha256_block_if.sv
// Request/response bundle between the hash controller and sha256_block.
interface sha256_block_if;
  logic         start;
  logic [511:0] msg;
  logic [255:0] h_in;
  logic         busy;
  logic         done;
  logic [255:0] h_out;

  modport master (output start, output msg, output h_in,
                  input  busy,  input  done, input  h_out);

  modport slave  (input  start, input  msg, input  h_in,
                  output busy,  output done, output h_out);
endinterface

// File: rtl/sha256_wsched.sv
// Message schedule: 16-word sliding window holding W[t]..W[t+15].
// The oldest word is the current round's Wt; each shift appends W[t+16].
module sha256_wsched
  import sha256_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [511:0] msg,
  input  logic         shift,
  input  logic [5:0]   t,
  output word_t        wt
);

  word_t w [16];
  word_t w_next;

  // W[t+16] is only consumed while t <= 47; later rounds shift in zero
  // so the expansion adders stop toggling during the tail of the block.
  assign w_next = (t < 6'd48) ? (s1(w[14]) + w[9] + s0(w[1]) + w[0]) : '0;
  assign wt     = w[0];

  // Load the block on accept, then slide one word per round
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) w[i] <= '0;
    end else if (load) begin
      for (int i = 0; i < 16; i++) w[i] <= msg[511 - 32*i -: 32];
    end else if (shift) begin
      for (int i = 0; i < 15; i++) w[i] <= w[i+1];
      w[15] <= w_next;
    end
  end

endmodule

// File: rtl/sha256_block.sv
// Single-block SHA-256 compression, one round per clock, non-pipelined.
//
// state    | meaning
// ST_IDLE  | waiting for start; done holds its pulse for one cycle only
// ST_ROUND | 64 rounds, t = 0..63
// ST_FINAL | add chaining value, publish h_out, pulse done
module sha256_block
  import sha256_pkg::*;
#(
  parameter bit USE_IV = 1'b0
) (
  input  logic          clk,
  input  logic          reset,
  sha256_block_if.slave bus
);

  fsm_t       state;
  logic [5:0] t;
  state_t     work;
  state_t     hsave;
  state_t     h_sel;
  word_t      wt;
  logic       load;
  logic       shift;

  assign h_sel = USE_IV ? IV : state_t'(bus.h_in);
  assign load  = (state == ST_IDLE) && bus.start;
  assign shift = (state == ST_ROUND);

  sha256_wsched u_wsched (
    .clk   (clk),
    .reset (reset),
    .load  (load),
    .msg   (bus.msg),
    .shift (shift),
    .t     (t),
    .wt    (wt)
  );

  // Control FSM and a..h datapath with registered handshake outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      t         <= '0;
      work      <= '0;
      hsave     <= '0;
      bus.busy  <= 1'b0;
      bus.done  <= 1'b0;
      bus.h_out <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          bus.done <= 1'b0;
          if (bus.start) begin
            hsave    <= h_sel;
            work     <= h_sel;
            t        <= '0;
            bus.busy <= 1'b1;
            state    <= ST_ROUND;
          end
        end
        ST_ROUND: begin
          work <= round(work, wt, K[t]);
          t    <= t + 6'd1;
          if (t == 6'd63) state <= ST_FINAL;
        end
        ST_FINAL: begin
          bus.h_out <= add_state(hsave, work);
          bus.done  <= 1'b1;
          bus.busy  <= 1'b0;
          state     <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_block.sv
// Bench for sha256_block: two instances (fixed IV and external chaining
// value) checked every cycle against a cycle-count model whose digest is
// a plain SHA-256 compression, plus literal digests of known messages.
module tb_sha256_block;

  localparam logic [31:0] KT [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };
  localparam logic [255:0] IV_REF = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;

  localparam logic [511:0] MSG_ABC   = {32'h61626380, 448'd0, 32'h00000018};
  localparam logic [511:0] MSG_EMPTY = {32'h80000000, 480'd0};
  localparam logic [511:0] MSG_TWO1  = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                                        32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                                        32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                                        32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
  localparam logic [511:0] MSG_TWO2  = {480'd0, 32'h000001c0};
  localparam logic [255:0] DIG_ABC   = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] DIG_EMPTY = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
  localparam logic [255:0] DIG_TWO   = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic         start_r [2];
  logic [511:0] msg_r   [2];
  logic [255:0] hin_r   [2];

  sha256_block_if ifc0 ();
  sha256_block_if ifc1 ();

  assign ifc0.start = start_r[0];
  assign ifc0.msg   = msg_r[0];
  assign ifc0.h_in  = hin_r[0];
  assign ifc1.start = start_r[1];
  assign ifc1.msg   = msg_r[1];
  assign ifc1.h_in  = hin_r[1];

  sha256_block #(.USE_IV(1'b1)) dut0 (.clk(clk), .reset(reset), .bus(ifc0.slave));
  sha256_block #(.USE_IV(1'b0)) dut1 (.clk(clk), .reset(reset), .bus(ifc1.slave));

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_cnt [2] = '{0, 0};

  logic         m_busy  [2];
  logic         m_done  [2];
  logic [255:0] m_hout  [2];
  logic [255:0] m_exp   [2];
  int           m_cnt   [2];
  int           acc_cyc [2];

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Textbook SHA-256 compression of one block
  function automatic logic [255:0] ref_compress(input logic [255:0] h, input logic [511:0] m);
    logic [31:0] w [64];
    logic [31:0] v [8];
    logic [31:0] t1, t2, x, y;
    logic [255:0] r;
    for (int i = 0; i < 16; i++) w[i] = m[511 - 32*i -: 32];
    for (int i = 16; i < 64; i++) begin
      x = w[i-15];
      y = w[i-2];
      w[i] = (ror(y, 17) ^ ror(y, 19) ^ (y >> 10)) + w[i-7] + (ror(x, 7) ^ ror(x, 18) ^ (x >> 3)) + w[i-16];
    end
    for (int i = 0; i < 8; i++) v[i] = h[255 - 32*i -: 32];
    for (int i = 0; i < 64; i++) begin
      t1 = v[7] + (ror(v[4], 6) ^ ror(v[4], 11) ^ ror(v[4], 25)) + ((v[4] & v[5]) ^ (~v[4] & v[6])) + KT[i] + w[i];
      t2 = (ror(v[0], 2) ^ ror(v[0], 13) ^ ror(v[0], 22)) + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
      v[7] = v[6]; v[6] = v[5]; v[5] = v[4]; v[4] = v[3] + t1;
      v[3] = v[2]; v[2] = v[1]; v[1] = v[0]; v[0] = t1 + t2;
    end
    for (int i = 0; i < 8; i++) r[255 - 32*i -: 32] = h[255 - 32*i -: 32] + v[i];
    return r;
  endfunction

  function automatic logic [511:0] rand512();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual %h required %h", nm, act, req);
    end
  endtask

  // Reference model: accept in idle, result and done 65 edges later
  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        m_busy[k] <= 1'b0;
        m_done[k] <= 1'b0;
        m_hout[k] <= '0;
        m_cnt[k]  <= 0;
      end else if (!m_busy[k]) begin
        m_done[k] <= 1'b0;
        if (start_r[k]) begin
          m_busy[k]  <= 1'b1;
          m_cnt[k]   <= 0;
          acc_cyc[k] <= cyc + 1;
          m_exp[k]   <= ref_compress((k == 0) ? IV_REF : hin_r[k], msg_r[k]);
        end
      end else begin
        m_cnt[k] <= m_cnt[k] + 1;
        if (m_cnt[k] == 64) begin
          m_busy[k] <= 1'b0;
          m_done[k] <= 1'b1;
          m_hout[k] <= m_exp[k];
        end
      end
    end
  end

  // Every-cycle comparison of both instances against the model
  always @(negedge clk) begin
    logic         b, d;
    logic [255:0] ho;
    for (int k = 0; k < 2; k++) begin
      b  = (k == 0) ? ifc0.busy  : ifc1.busy;
      d  = (k == 0) ? ifc0.done  : ifc1.done;
      ho = (k == 0) ? ifc0.h_out : ifc1.h_out;
      if (d === 1'b1) done_cnt[k] <= done_cnt[k] + 1;
      if (reset) begin
        chk($sformatf("busy_rst%0d", k), 256'(b), 256'(0));
        chk($sformatf("done_rst%0d", k), 256'(d), 256'(0));
        chk($sformatf("hout_rst%0d", k), ho, '0);
      end else begin
        chk($sformatf("busy%0d@%0d", k, cyc), 256'(b), 256'(m_busy[k]));
        chk($sformatf("done%0d@%0d", k, cyc), 256'(d), 256'(m_done[k]));
        chk($sformatf("hout%0d@%0d", k, cyc), ho, m_hout[k]);
      end
    end
  end

  task automatic start_block(input int k, input logic [511:0] m, input logic [255:0] h);
    start_r[k] = 1'b1;
    msg_r[k]   = m;
    hin_r[k]   = h;
    @(posedge clk);
    #2;
    start_r[k] = 1'b0;
    msg_r[k]   = rand512();
    hin_r[k]   = rand256();
  endtask

  task automatic wait_done(input int k, input string nm);
    bit seen = 1'b0;
    int n = 0;
    while (!seen && n < 200) begin
      @(negedge clk);
      n++;
      seen = (k == 0) ? (ifc0.done === 1'b1) : (ifc1.done === 1'b1);
    end
    chk({nm, "_done_seen"}, 256'(seen), 256'(1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    int d0;
    logic [255:0] h1, hr;
    logic [511:0] mr;
    reset = 1'b1;
    for (int k = 0; k < 2; k++) begin
      start_r[k] = 1'b0;
      msg_r[k]   = '0;
      hin_r[k]   = '0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_busy0", 256'(ifc0.busy), 256'(0));
    chk("reset_done1", 256'(ifc1.done), 256'(0));
    chk("reset_hout1", ifc1.h_out, '0);
    @(posedge clk);
    #2 reset = 1'b0;
    repeat (2) @(posedge clk);
    #2;

    // Model pinned to published digests
    chk("model_abc",   ref_compress(IV_REF, MSG_ABC), DIG_ABC);
    chk("model_empty", ref_compress(IV_REF, MSG_EMPTY), DIG_EMPTY);
    chk("model_two",   ref_compress(ref_compress(IV_REF, MSG_TWO1), MSG_TWO2), DIG_TWO);

    // "abc" on the fixed-IV instance, h_in deliberately garbage
    start_block(0, MSG_ABC, rand256());
    wait_done(0, "abc");
    chk("abc_latency", 256'(cyc - acc_cyc[0]), 256'(65));
    chk("abc_digest", ifc0.h_out, DIG_ABC);

    // Empty string via external chaining value
    start_block(1, MSG_EMPTY, IV_REF);
    wait_done(1, "empty");
    chk("empty_digest", ifc1.h_out, DIG_EMPTY);

    // Two-block chain, second block accepted in the done cycle
    start_block(1, MSG_TWO1, IV_REF);
    wait_done(1, "two1");
    h1 = ref_compress(IV_REF, MSG_TWO1);
    start_block(1, MSG_TWO2, h1);
    chk("b2b_busy", 256'(ifc1.busy), 256'(1));
    chk("b2b_done", 256'(ifc1.done), 256'(0));
    wait_done(1, "two2");
    chk("two_digest", ifc1.h_out, DIG_TWO);

    // Start pulses while busy are ignored
    repeat (3) @(posedge clk);
    #2;
    d0 = done_cnt[0];
    start_block(0, MSG_ABC, rand256());
    repeat (9) @(posedge clk);
    #2;
    start_block(0, rand512(), rand256());
    repeat (29) @(posedge clk);
    #2;
    start_block(0, rand512(), rand256());
    repeat (70) @(negedge clk);
    chk("busy_start_one_done", 256'(done_cnt[0] - d0), 256'(1));
    chk("busy_start_digest", ifc0.h_out, DIG_ABC);

    // Reset around round 30 aborts without a done pulse
    start_block(0, MSG_ABC, rand256());
    repeat (29) @(posedge clk);
    #2;
    d0 = done_cnt[0];
    reset = 1'b1;
    #1;
    chk("abort_busy", 256'(ifc0.busy), 256'(0));
    chk("abort_hout", ifc0.h_out, '0);
    @(posedge clk);
    #2 reset = 1'b0;
    repeat (80) @(negedge clk);
    chk("abort_no_done", 256'(done_cnt[0] - d0), 256'(0));
    start_block(0, MSG_ABC, rand256());
    wait_done(0, "abc_after_abort");
    chk("abc_after_abort", ifc0.h_out, DIG_ABC);

    // Random blocks and chaining values, some back-to-back
    for (int i = 0; i < 6; i++) begin
      mr = rand512();
      hr = rand256();
      start_block(1, mr, hr);
      wait_done(1, "rand");
      chk($sformatf("rand_digest%0d", i), ifc1.h_out, ref_compress(hr, mr));
      if (i % 2 == 0) repeat ($urandom_range(1, 5)) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
